// File: rtl/mac_weight_load_seq.sv
// Feeds 64-bit weight words into a MAC-quad shift chain one per cycle and closes each load
// with a single set_weight/done pulse.
module mac_weight_load_seq #(
  parameter int unsigned ARRAY_ROWS = 4,
  parameter int unsigned ROW_CNT_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [ROW_CNT_W-1:0] i_cfg_rows,
  input  logic                 i_wdata_valid,
  input  logic [63:0]          i_wdata,
  output logic                 o_wdata_ready,
  output logic                 o_prepare_weight,
  output logic                 o_set_weight,
  output logic [7:0]           o_load_weight_data_a_0,
  output logic [7:0]           o_load_weight_data_b_0,
  output logic [7:0]           o_load_weight_data_c_0,
  output logic [7:0]           o_load_weight_data_d_0,
  output logic [7:0]           o_load_weight_data_a_1,
  output logic [7:0]           o_load_weight_data_b_1,
  output logic [7:0]           o_load_weight_data_c_1,
  output logic [7:0]           o_load_weight_data_d_1,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [ROW_CNT_W-1:0] MaxRows = ROW_CNT_W'(ARRAY_ROWS);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StCommit} state_e;

  state_e                 state_q, state_d;
  logic [ROW_CNT_W-1:0]   rows_q, rows_d;
  logic [ROW_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   prep_q, prep_d;
  logic                   set_q, set_d;
  logic                   done_q, done_d;
  logic [63:0]            data_q, data_d;
  logic                   accept;
  logic                   last_word;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign accept    = i_wdata_valid && o_wdata_ready;
  assign last_word = (cnt_q == (rows_q - ROW_CNT_W'(1)));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_start) state_d = StLoad;
      StLoad:   if (accept && last_word) state_d = StFlush;
      StFlush:  state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output / datapath next values; data is forced to zero whenever no shift is presented
  always_comb begin
    o_wdata_ready = (state_q == StLoad);
    o_busy        = (state_q != StIdle);
    rows_d        = rows_q;
    cnt_d         = cnt_q;
    if ((state_q == StIdle) && i_start) begin
      rows_d = ((i_cfg_rows == '0) || (i_cfg_rows > MaxRows)) ? MaxRows : i_cfg_rows;
      cnt_d  = '0;
    end else if (accept) begin
      cnt_d = cnt_q + ROW_CNT_W'(1);
    end
    prep_d = accept;
    data_d = accept ? i_wdata : 64'h0;
    set_d  = (state_q == StFlush);
    done_d = (state_q == StFlush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q <= '0;
      cnt_q  <= '0;
      prep_q <= 1'b0;
      set_q  <= 1'b0;
      done_q <= 1'b0;
      data_q <= 64'h0;
    end else begin
      rows_q <= rows_d;
      cnt_q  <= cnt_d;
      prep_q <= prep_d;
      set_q  <= set_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end

  assign o_prepare_weight       = prep_q;
  assign o_set_weight           = set_q;
  assign o_done                 = done_q;
  assign o_load_weight_data_a_0 = data_q[7:0];
  assign o_load_weight_data_b_0 = data_q[15:8];
  assign o_load_weight_data_c_0 = data_q[23:16];
  assign o_load_weight_data_d_0 = data_q[31:24];
  assign o_load_weight_data_a_1 = data_q[39:32];
  assign o_load_weight_data_b_1 = data_q[47:40];
  assign o_load_weight_data_c_1 = data_q[55:48];
  assign o_load_weight_data_d_1 = data_q[63:56];

endmodule
